// File: rtl/ssd_scan_controller.sv
// rtl/ssd_scan_controller.sv - four-digit seven-segment scan controller
// Frame-synchronous digit update, anti-ghost guard band, leading-zero blanking.
module ssd_scan_controller #(
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD         = 16,
  parameter int BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  input  logic [3:0] D4,
  input  logic       load,
  input  logic [3:0] dp_sel,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       frame_done
);

  localparam int          CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [31:0] GUARD_U  = 32'(GUARD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    disp_dp_q, disp_dp_d;
  logic [15:0]   pend_q, pend_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_flag_q, pend_flag_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic          wrap;
  logic          boundary;
  logic          in_guard;
  logic [3:0]    cur_digit;
  logic          cur_dp;
  logic          blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  // Slot timing and frame-synchronous register transfer
  always_comb begin
    wrap        = (cnt_q == CNT_LAST);
    boundary    = wrap && (slot_q == 2'd3);
    cnt_d       = wrap ? '0 : cnt_q + 1'b1;
    slot_d      = wrap ? slot_q + 2'd1 : slot_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    if (boundary) begin
      pend_flag_d = 1'b0;
      if (load) begin
        disp_d    = {D1, D2, D3, D4};
        disp_dp_d = dp_sel;
      end else if (pend_flag_q) begin
        disp_d    = pend_q;
        disp_dp_d = pend_dp_q;
      end
    end else if (load) begin
      pend_d      = {D1, D2, D3, D4};
      pend_dp_d   = dp_sel;
      pend_flag_d = 1'b1;
    end
  end

  // Digit selection and blanking for the current slot
  always_comb begin
    in_guard  = ({{(32-CW){1'b0}}, cnt_q} < GUARD_U);
    cur_digit = disp_q[3:0];
    cur_dp    = disp_dp_q[0];
    blank     = 1'b0;
    case (slot_q)
      2'd0: begin
        cur_digit = disp_q[15:12];
        cur_dp    = disp_dp_q[3];
        blank     = (disp_q[15:12] == 4'd0);
      end
      2'd1: begin
        cur_digit = disp_q[11:8];
        cur_dp    = disp_dp_q[2];
        blank     = (disp_q[15:8] == 8'd0);
      end
      2'd2: begin
        cur_digit = disp_q[7:4];
        cur_dp    = disp_dp_q[1];
        blank     = (disp_q[15:4] == 12'd0);
      end
      default: begin
        cur_digit = disp_q[3:0];
        cur_dp    = disp_dp_q[0];
        blank     = 1'b0;
      end
    endcase
    if (BLANK_LEADING == 0) blank = 1'b0;

    an_d         = 4'b1111;
    seg_d        = 7'b1111111;
    dp_d         = 1'b1;
    frame_done_d = boundary;
    if (!in_guard) begin
      an_d  = ~(4'b1000 >> slot_q);
      seg_d = blank ? 7'b1111111 : seg_decode(cur_digit);
      dp_d  = ~cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      slot_q       <= 2'd0;
      disp_q       <= 16'd0;
      disp_dp_q    <= 4'd0;
      pend_q       <= 16'd0;
      pend_dp_q    <= 4'd0;
      pend_flag_q  <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb/tb_ssd_scan_controller.sv - self-checking bench for ssd_scan_controller
// Reference model tracks scan position arithmetically and latches digits at frame ends.
module tb_ssd_scan_controller;

  localparam int RDIV  = 8;
  localparam int GRD   = 2;
  localparam int BL    = 1;
  localparam int FRAME = 4 * RDIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D1, D2, D3, D4;
  logic       load;
  logic [3:0] dp_sel;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_pulses = 0;

  // model state
  int         m_p;
  logic [3:0] m_disp [4];
  logic [3:0] m_dp;
  logic [3:0] m_pend [4];
  logic [3:0] m_pend_dp;
  bit         m_pend_flag;

  ssd_scan_controller #(.REFRESH_DIV(RDIV), .GUARD(GRD), .BLANK_LEADING(BL)) dut (
    .clk(clk), .rst(rst), .D1(D1), .D2(D2), .D3(D3), .D4(D4),
    .load(load), .dp_sel(dp_sel), .AN(AN), .SEG(SEG), .DP(DP), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b at p=%0d", tag, obs, exp, m_p);
    end
  endtask

  task automatic tick();
    int slot, cnt;
    logic [3:0] ea;
    logic [6:0] es;
    logic ed, ef;
    bit blank;
    bit bnd;
    ea = 4'hF; es = 7'h7F; ed = 1'b1; ef = 1'b0;
    if (!rst) begin
      slot = (m_p / RDIV) % 4;
      cnt  = m_p % RDIV;
      bnd  = ((m_p % FRAME) == FRAME - 1);
      ef   = bnd;
      if (cnt >= GRD) begin
        ea[3-slot] = 1'b0;
        blank = (BL != 0) && (slot < 3);
        for (int i = 0; i <= slot; i++) if (m_disp[i] != 4'd0) blank = 0;
        es = blank ? 7'h7F : ref_seg(m_disp[slot]);
        ed = ~m_dp[3-slot];
      end
      if (bnd) begin
        if (load) begin
          m_disp = '{D1, D2, D3, D4};
          m_dp   = dp_sel;
        end else if (m_pend_flag) begin
          m_disp = m_pend;
          m_dp   = m_pend_dp;
        end
        m_pend_flag = 0;
      end else if (load) begin
        m_pend      = '{D1, D2, D3, D4};
        m_pend_dp   = dp_sel;
        m_pend_flag = 1;
      end
      m_p++;
    end else begin
      m_p = 0;
      m_disp = '{4'd0, 4'd0, 4'd0, 4'd0};
      m_pend = '{4'd0, 4'd0, 4'd0, 4'd0};
      m_dp = 4'd0; m_pend_dp = 4'd0; m_pend_flag = 0;
    end
    @(posedge clk);
    #1;
    chk("an", {3'b000, AN}, {3'b000, ea});
    chk("seg", SEG, es);
    chk("dp", {6'd0, DP}, {6'd0, ed});
    chk("frame_done", {6'd0, frame_done}, {6'd0, ef});
    if (frame_done) fd_pulses++;
  endtask

  task automatic do_load(input logic [3:0] a, b, c, d, input logic [3:0] dp);
    D1 = a; D2 = b; D3 = c; D4 = d; dp_sel = dp; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && (m_p % FRAME) != pos; i++) tick();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; D1 = 0; D2 = 0; D3 = 0; D4 = 0; dp_sel = 0;
    m_p = 0;

    // reset for three cycles, then release
    run(3);
    rst = 1'b0;
    run(2);
    chk("post_reset_an_dark", {3'b000, AN}, 7'b0001111);
    chk("post_reset_seg_dark", SEG, 7'b1111111);
    tick();
    chk("first_slot_an", {3'b000, AN}, 7'b0000111);
    chk("first_slot_blanked", SEG, 7'b1111111);

    // 1234 with point on the tens digit
    run(4);
    do_load(4'd1, 4'd2, 4'd3, 4'd4, 4'b0010);
    run(2 * FRAME);

    // leading-zero blanking cases and dash code
    do_load(4'd0, 4'd0, 4'd0, 4'd7, 4'b0000);
    run(FRAME + 8);
    do_load(4'd0, 4'd0, 4'd0, 4'd0, 4'b1000);
    run(FRAME + 8);
    do_load(4'd1, 4'hC, 4'd0, 4'd9, 4'b0001);
    run(FRAME + 8);

    // two mid-frame loads: last wins, only at the boundary
    run_to(5);
    do_load(4'd1, 4'd1, 4'd1, 4'd1, 4'b0000);
    run(3);
    do_load(4'd2, 4'd2, 4'd2, 4'd2, 4'b0000);
    run(2 * FRAME);

    // load coinciding with the boundary goes straight to display
    run_to(FRAME - 1);
    do_load(4'd5, 4'd5, 4'd5, 4'd5, 4'b0000);
    run(3);
    chk("boundary_load_d1", SEG, 7'b0010010);
    run(FRAME);

    // randomized loads with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        D1 = 4'($urandom); D2 = 4'($urandom); D3 = 4'($urandom); D4 = 4'($urandom);
        if ($urandom_range(0, 1) == 0) begin D1 = 0; if ($urandom_range(0, 1) == 0) D2 = 0; end
        dp_sel = 4'($urandom);
        load = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      tick();
      load = 1'b0; rst = 1'b0;
    end

    // reset during slot 2 discards a pending load
    run_to(2 * RDIV + 2);
    do_load(4'd9, 4'd9, 4'd9, 4'd9, 4'b1111);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset_an", {3'b000, AN}, 7'b0001111);
    chk("mid_reset_seg", SEG, 7'b1111111);
    chk("mid_reset_dp", {6'd0, DP}, 7'd1);
    chk("mid_reset_fd", {6'd0, frame_done}, 7'd0);
    fd_pulses = 0;
    run(2 * FRAME);
    chk("fd_pulses_per_two_frames", 7'(fd_pulses), 7'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
